serial_cmp_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit unsigned operands MSB-first, 2 bits per clock, through a single 2-bit magnitude-compare slice.
- Trades latency for area. Used where wide compares are infrequent and a full-width comparator is not justified.
- Valid/ready on both input and output sides. Sits between an operand producer and a result consumer.

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/serial_cmp_ctrl_cmp2_slice.sv | 15 +
 rtl/serial_cmp_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_cmp_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator.
// Holds FSM states, the 2-bit result code and the digit-count helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_LT = 2'd1,
        RES_GT = 2'd2
    } res_t;

    // Number of 2-bit digits in a WIDTH-bit operand.
    function automatic int ndig(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/serial_cmp_ctrl_cmp2_slice.sv
// 2-bit unsigned magnitude compare slice, purely combinational.
// Ports: a, b (2-bit digits); lt, eq, gt (exactly one high).
module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial MSB-first unsigned comparator, one 2-bit digit per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a_in, b_in;
//        out_valid/out_ready, a_lt_b, a_eq_b, a_gt_b, digits_used, busy.
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            a_in,
    input  logic [WIDTH-1:0]            b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        a_lt_b,
    output logic                        a_eq_b,
    output logic                        a_gt_b,
    output logic [$clog2(WIDTH/2):0]    digits_used,
    output logic                        busy
);

    localparam int NDIG = ndig(WIDTH);
    localparam int DW   = $clog2(NDIG) + 1;
    localparam logic [DW-1:0] LAST = DW'(NDIG - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    res_t              dec_q, dec_d;
    logic              lt_q, lt_d;
    logic              eq_q, eq_d;
    logic              gt_q, gt_d;
    logic [DW-1:0]     used_q, used_d;

    logic sl_lt, sl_eq, sl_gt;
    res_t dig_res;
    res_t new_dec;
    logic stop;

    // The current digit is always the top two bits of the shift regs.
    cmp2_slice u_slice (
        .a  (sh_a_q[WIDTH-1 -: 2]),
        .b  (sh_b_q[WIDTH-1 -: 2]),
        .lt (sl_lt),
        .eq (sl_eq),
        .gt (sl_gt)
    );

    always_comb begin
        dig_res = RES_EQ;
        unique case (1'b1)
            sl_lt:   dig_res = RES_LT;
            sl_gt:   dig_res = RES_GT;
            sl_eq:   dig_res = RES_EQ;
            default: dig_res = RES_EQ;
        endcase
    end

    // Sticky: the first unequal digit wins, later digits are ignored.
    assign new_dec = (dec_q == RES_EQ) ? dig_res : dec_q;

    assign stop = (cnt_q == LAST)
               || ((EARLY_EXIT != 0) && (dig_res != RES_EQ));

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        used_d  = used_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sh_a_d  = a_in;
                    sh_b_d  = b_in;
                    cnt_d   = '0;
                    dec_d   = RES_EQ;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sh_a_d = sh_a_q << 2;
                sh_b_d = sh_b_q << 2;
                cnt_d  = cnt_q + DW'(1);
                dec_d  = new_dec;
                if (stop) begin
                    lt_d    = (new_dec == RES_LT);
                    eq_d    = (new_dec == RES_EQ);
                    gt_d    = (new_dec == RES_GT);
                    used_d  = cnt_q + DW'(1);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            dec_q   <= RES_EQ;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            used_q  <= used_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE) && !rst;
    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign a_lt_b      = lt_q;
    assign a_eq_b      = eq_q;
    assign a_gt_b      = gt_q;
    assign digits_used = used_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl (WIDTH=8).
// Instance 0 uses EARLY_EXIT=1, instance 1 uses EARLY_EXIT=0.
module tb_serial_cmp_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] a_in, b_in;
    logic       out_valid, out_ready;
    logic       a_lt_b, a_eq_b, a_gt_b;
    logic [2:0] digits_used;
    logic       busy;

    logic       in_valid1, in_ready1;
    logic [7:0] a_in1, b_in1;
    logic       out_valid1, out_ready1;
    logic       a_lt_b1, a_eq_b1, a_gt_b1;
    logic [2:0] digits_used1;
    logic       busy1;

    int total;
    int pass;

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b),
        .digits_used(digits_used), .busy(busy)
    );

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a_in(a_in1), .b_in(b_in1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .a_lt_b(a_lt_b1), .a_eq_b(a_eq_b1), .a_gt_b(a_gt_b1),
        .digits_used(digits_used1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Digits examined: index of the first differing 2-bit digit
    // (from the MSB side) plus one, or all four without early exit.
    function automatic int exp_used(input logic [7:0] a,
                                    input logic [7:0] b,
                                    input bit early);
        logic [7:0] x;
        int d;
        x = a ^ b;
        if (!early || x == 8'h00) return 4;
        d = -1;
        for (int p = 7; p >= 0; p--) begin
            if (x[p] && d < 0) d = (7 - p) / 2;
        end
        return d + 1;
    endfunction

    task automatic issue0(input logic [7:0] a, input logic [7:0] b);
        int n;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
        end else pass++;
        step;
        in_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
    endtask

    task automatic finish0(input logic [7:0] a, input logic [7:0] b,
                           input int bp, input string nm);
        int n;
        int used;
        logic [2:0] e_fl;
        logic [2:0] fl;
        logic [2:0] du;
        used = exp_used(a, b, 1'b1);
        e_fl = {a < b, a == b, a > b};
        out_ready = (bp == 0);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL %s run_state: busy=%b in_ready=%b out_valid=%b want 1 0 0",
                     nm, busy, in_ready, out_valid);
        end else pass++;
        n = 0;
        while (!out_valid && n < 20) begin
            step;
            n++;
        end
        total++;
        if (n !== used || out_valid !== 1'b1) begin
            $display("FAIL %s latency: got %0d cycles (ov=%b) want %0d",
                     nm, n, out_valid, used);
        end else pass++;
        fl = {a_lt_b, a_eq_b, a_gt_b};
        du = digits_used;
        total++;
        if (fl !== e_fl) begin
            $display("FAIL %s flags: lt/eq/gt=%b want %b (a=%h b=%h)",
                     nm, fl, e_fl, a, b);
        end else pass++;
        total++;
        if (du !== 3'(used)) begin
            $display("FAIL %s digits_used: got %0d want %0d", nm, du, used);
        end else pass++;
        for (int i = 0; i < bp; i++) begin
            step;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0
                || {a_lt_b, a_eq_b, a_gt_b} !== e_fl
                || digits_used !== 3'(used)) begin
                $display("FAIL %s hold: ov=%b ir=%b fl=%b du=%0d want 1 0 %b %0d",
                         nm, out_valid, in_ready, {a_lt_b, a_eq_b, a_gt_b},
                         digits_used, e_fl, used);
            end else pass++;
        end
        out_ready = 1'b1;
        step;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1",
                     nm, out_valid, in_ready);
        end else pass++;
        out_ready = 1'b0;
    endtask

    task automatic txn1(input logic [7:0] a, input logic [7:0] b,
                        input string nm);
        int n;
        logic [2:0] e_fl;
        e_fl = {a < b, a == b, a > b};
        a_in1 = a;
        b_in1 = b;
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        n = 0;
        while (!in_ready1 && n < 20) begin
            step;
            n++;
        end
        step;
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            step;
            n++;
        end
        total++;
        if (n !== 4 || out_valid1 !== 1'b1) begin
            $display("FAIL %s latency1: got %0d cycles want 4", nm, n);
        end else pass++;
        total++;
        if ({a_lt_b1, a_eq_b1, a_gt_b1} !== e_fl || digits_used1 !== 3'd4) begin
            $display("FAIL %s result1: fl=%b du=%0d want %b 4 (a=%h b=%h)",
                     nm, {a_lt_b1, a_eq_b1, a_gt_b1}, digits_used1, e_fl, a, b);
        end else pass++;
        step;
        total++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            $display("FAIL %s release1: ov=%b ir=%b want 0 1",
                     nm, out_valid1, in_ready1);
        end else pass++;
        out_ready1 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        total++;
        if ({out_valid, a_lt_b, a_eq_b, a_gt_b, busy, in_ready} !== 6'b0
            || digits_used !== 3'd0) begin
            $display("FAIL reset_outputs: ov,lt,eq,gt,busy,ir=%b du=%0d want 0",
                     {out_valid, a_lt_b, a_eq_b, a_gt_b, busy, in_ready},
                     digits_used);
        end else pass++;
        total++;
        if ({out_valid1, busy1, in_ready1} !== 3'b0) begin
            $display("FAIL reset_outputs1: ov,busy,ir=%b want 000",
                     {out_valid1, busy1, in_ready1});
        end else pass++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            $display("FAIL reset_release: in_ready=%b in_ready1=%b want 1 1",
                     in_ready, in_ready1);
        end else pass++;
    endtask

    task automatic test_directed;
        issue0(8'hA5, 8'hA5);
        finish0(8'hA5, 8'hA5, 0, "eq_a5");
        issue0(8'h80, 8'h7F);
        finish0(8'h80, 8'h7F, 0, "gt_msd");
        issue0(8'h12, 8'h13);
        finish0(8'h12, 8'h13, 0, "lt_lsd");
    endtask

    task automatic test_backpressure;
        issue0(8'h01, 8'h02);
        a_in = 8'hC3;
        b_in = 8'h3C;
        in_valid = 1'b1;
        finish0(8'h01, 8'h02, 3, "bp");
        step;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL bp_second_accept: busy=%b in_ready=%b want 1 0",
                     busy, in_ready);
        end else pass++;
        finish0(8'hC3, 8'h3C, 0, "bp_second");
    endtask

    task automatic test_reset_mid_run;
        int seen;
        issue0(8'h00, 8'h01);
        step;
        rst = 1'b1;
        step;
        total++;
        if ({out_valid, a_lt_b, a_eq_b, a_gt_b, busy, in_ready} !== 6'b0
            || digits_used !== 3'd0) begin
            $display("FAIL midrun_reset: ov,lt,eq,gt,busy,ir=%b du=%0d want 0",
                     {out_valid, a_lt_b, a_eq_b, a_gt_b, busy, in_ready},
                     digits_used);
        end else pass++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL midrun_ready: in_ready=%b want 1", in_ready);
        end else pass++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            $display("FAIL midrun_abandon: %0d cycles with ov/busy, want 0", seen);
        end else pass++;
    endtask

    task automatic test_back_to_back;
        logic [8:0] ov_seen, ir_seen, ov_exp, ir_exp;
        int n;
        a_in = 8'h80;
        b_in = 8'h7F;
        out_ready = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        for (int i = 0; i < 9; i++) begin
            step;
            ov_seen[i] = out_valid;
            ir_seen[i] = in_ready;
            ov_exp[i]  = (i % 3 == 1);
            ir_exp[i]  = (i % 3 == 2);
        end
        in_valid = 1'b0;
        total++;
        if (ov_seen !== ov_exp) begin
            $display("FAIL b2b_out_valid: pattern=%b want %b", ov_seen, ov_exp);
        end else pass++;
        total++;
        if (ir_seen !== ir_exp) begin
            $display("FAIL b2b_in_ready: pattern=%b want %b", ir_seen, ir_exp);
        end else pass++;
        step;
        step;
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        int r;
        for (int t = 0; t < 30; t++) begin
            a = 8'($urandom);
            r = $urandom_range(0, 3);
            if (r == 0) b = a;
            else if (r == 1) b = a ^ (8'h01 << $urandom_range(0, 7));
            else b = 8'($urandom);
            issue0(a, b);
            finish0(a, b, $urandom_range(0, 2), "rand");
        end
    endtask

    task automatic test_no_early_exit;
        logic [7:0] a, b;
        txn1(8'h43, 8'h3C, "ne_first_wins");
        txn1(8'h5A, 8'h5A, "ne_eq");
        for (int t = 0; t < 10; t++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
            txn1(a, b, "ne_rand");
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        out_ready = 1'b0;
        in_valid1 = 1'b0;
        a_in1 = 8'h00;
        b_in1 = 8'h00;
        out_ready1 = 1'b0;
        total = 0;
        pass = 0;
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        test_no_early_exit;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
